// File: rtl/prog_mod_counter_if.sv
// Control/status bundle for prog_mod_counter: step, load and modulus-write requests
// from the master, count value, active modulus and pulse flags from the counter.
interface prog_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             i_en;
  logic             i_up_down;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;
  logic             i_mod_wr;
  logic [WIDTH:0]   i_mod_val;
  logic [WIDTH-1:0] o_Q;
  logic [WIDTH:0]   o_mod;
  logic             o_tc;
  logic             o_err;

  modport master (
    output i_en, i_up_down, i_load, i_load_val, i_mod_wr, i_mod_val,
    input  o_Q, o_mod, o_tc, o_err
  );

  modport slave (
    input  i_en, i_up_down, i_load, i_load_val, i_mod_wr, i_mod_val,
    output o_Q, o_mod, o_tc, o_err
  );
endinterface

// File: rtl/prog_mod_counter.sv
// Up/down counter with run-time modulus, synchronous load, wrap/saturate mode and
// registered terminal-count pulse. Optional prescaler: PROG_MOD_COUNTER_PRESCALE_EN.
module prog_mod_counter #(
  parameter int WIDTH     = 4,
  parameter int N_DEFAULT = 10,
  parameter int SATURATE  = 0,
  parameter int PRE_DIV   = 4
) (
  input logic             i_clk,
  input logic             i_rst,
  prog_mod_counter_if.slave bus
);

  localparam logic [WIDTH:0] MOD_MAX = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] MOD_RST = (WIDTH+1)'(N_DEFAULT);
  localparam logic [WIDTH:0] MOD_MIN = (WIDTH+1)'(2);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);
  localparam bit             SAT     = (SATURATE != 0);

  generate
    if (N_DEFAULT < 2 || N_DEFAULT > (1 << WIDTH)) begin : g_bad_n_default
      $error("prog_mod_counter: N_DEFAULT out of range 2..2^WIDTH");
    end
    if (PRE_DIV < 1) begin : g_bad_pre_div
      $error("prog_mod_counter: PRE_DIV must be >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH:0]   mod_reg, mod_next;
  logic             tc_reg, tc_next;
  logic             err_reg, err_next;

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   top;
  logic             at_top, at_zero, near_top, near_zero;
  logic             mod_ok, load_ok;
  logic             tick;
  logic             step;

  // All range checks in WIDTH+1 bits so a modulus of 2^WIDTH is a plain binary wrap.
  assign q_ext     = {1'b0, q_reg};
  assign top       = mod_reg - ONE_EXT;
  assign at_top    = (q_ext == top);
  assign at_zero   = (q_reg == '0);
  assign near_top  = (q_ext == top - ONE_EXT);
  assign near_zero = (q_reg == WIDTH'(1));
  assign mod_ok    = (bus.i_mod_val >= MOD_MIN) && (bus.i_mod_val <= MOD_MAX);
  assign load_ok   = ({1'b0, bus.i_load_val} < mod_reg);
  assign step      = bus.i_en & tick;

`ifdef PROG_MOD_COUNTER_PRESCALE_EN
  localparam int             PW       = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PW-1:0]  PSC_LAST = PW'(PRE_DIV - 1);

  logic [PW-1:0] psc_reg;

  assign tick = (psc_reg == PSC_LAST);

  // Phase follows the same priority as the counter; a rejected modulus leaves it alone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      psc_reg <= '0;
    end else if (bus.i_mod_wr) begin
      if (mod_ok) psc_reg <= '0;
    end else if (bus.i_load) begin
      psc_reg <= '0;
    end else if (bus.i_en) begin
      psc_reg <= tick ? '0 : psc_reg + PW'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    q_next   = q_reg;
    mod_next = mod_reg;
    tc_next  = 1'b0;
    err_next = 1'b0;
    if (bus.i_mod_wr) begin
      if (mod_ok) begin
        mod_next = bus.i_mod_val;
        q_next   = '0;
      end else begin
        err_next = 1'b1;
      end
    end else if (bus.i_load) begin
      if (load_ok) begin
        q_next = bus.i_load_val;
      end else begin
        q_next   = top[WIDTH-1:0];
        err_next = 1'b1;
      end
    end else if (step) begin
      if (bus.i_up_down) begin
        if (at_top) begin
          if (!SAT) begin
            q_next  = '0;
            tc_next = 1'b1;
          end
        end else begin
          q_next  = q_reg + WIDTH'(1);
          tc_next = SAT && near_top;
        end
      end else begin
        if (at_zero) begin
          if (!SAT) begin
            q_next  = top[WIDTH-1:0];
            tc_next = 1'b1;
          end
        end else begin
          q_next  = q_reg - WIDTH'(1);
          tc_next = SAT && near_zero;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q_reg   <= '0;
      mod_reg <= MOD_RST;
      tc_reg  <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      q_reg   <= q_next;
      mod_reg <= mod_next;
      tc_reg  <= tc_next;
      err_reg <= err_next;
    end
  end

  assign bus.o_Q   = q_reg;
  assign bus.o_mod = mod_reg;
  assign bus.o_tc  = tc_reg;
  assign bus.o_err = err_reg;

endmodule

// File: tb/tb_prog_mod_counter.sv
// Directed bench for prog_mod_counter: wrap instance, saturate instance and a PRE_DIV=4
// instance whose expectations follow PROG_MOD_COUNTER_PRESCALE_EN.
module tb_prog_mod_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  prog_mod_counter_if #(.WIDTH(4)) bw ();
  prog_mod_counter_if #(.WIDTH(4)) bs ();
  prog_mod_counter_if #(.WIDTH(4)) bp ();

  prog_mod_counter #(.WIDTH(4), .N_DEFAULT(10), .SATURATE(0), .PRE_DIV(1)) u_wrap (
    .i_clk(clk), .i_rst(rst), .bus(bw));
  prog_mod_counter #(.WIDTH(4), .N_DEFAULT(10), .SATURATE(1), .PRE_DIV(1)) u_sat (
    .i_clk(clk), .i_rst(rst), .bus(bs));
  prog_mod_counter #(.WIDTH(4), .N_DEFAULT(10), .SATURATE(0), .PRE_DIV(4)) u_psc (
    .i_clk(clk), .i_rst(rst), .bus(bp));

  typedef struct {
    string      name;
    logic       en, ud, ld, mw;
    logic [3:0] lv;
    logic [4:0] mv;
    logic [3:0] q;
    logic [4:0] m;
    logic       tc, err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input int en, input int ud, input int ld, input int lv,
                     input int mw, input int mv, input int q, input int m, input int tc,
                     input int err);
    vec_t v;
    v.name = n;  v.en = 1'(en); v.ud = 1'(ud); v.ld = 1'(ld); v.lv = 4'(lv);
    v.mw = 1'(mw); v.mv = 5'(mv); v.q = 4'(q); v.m = 5'(m); v.tc = 1'(tc); v.err = 1'(err);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tcs;
    int exp_q;
    bw.i_en = 0; bw.i_up_down = 1; bw.i_load = 0; bw.i_load_val = '0; bw.i_mod_wr = 0; bw.i_mod_val = '0;
    bs.i_en = 0; bs.i_up_down = 1; bs.i_load = 0; bs.i_load_val = '0; bs.i_mod_wr = 0; bs.i_mod_val = '0;
    bp.i_en = 0; bp.i_up_down = 1; bp.i_load = 0; bp.i_load_val = '0; bp.i_mod_wr = 0; bp.i_mod_val = '0;

    // vectors start from q=7, mod=10 (left by the 27-step count)
    add("mod5",       1, 1, 0, 0,  1, 5,  0, 5,  0, 0);
    add("dn_wrap",    1, 0, 0, 0,  0, 0,  4, 5,  1, 0);
    add("dn_3",       1, 0, 0, 0,  0, 0,  3, 5,  0, 0);
    add("dn_2",       1, 0, 0, 0,  0, 0,  2, 5,  0, 0);
    add("mod1_bad",   1, 0, 0, 0,  1, 1,  2, 5,  0, 1);
    add("mod17_bad",  0, 0, 0, 0,  1, 17, 2, 5,  0, 1);
    add("idle",       0, 1, 0, 0,  0, 0,  2, 5,  0, 0);
    add("ld3",        0, 1, 1, 3,  0, 0,  3, 5,  0, 0);
    add("ld9_clamp",  0, 1, 1, 9,  0, 0,  4, 5,  0, 1);
    add("ld_mw_en",   1, 1, 1, 1,  1, 8,  0, 8,  0, 0);
    add("up_1",       1, 1, 0, 0,  0, 0,  1, 8,  0, 0);
    add("mod16",      0, 1, 0, 0,  1, 16, 0, 16, 0, 0);
    add("dn_full",    1, 0, 0, 0,  0, 0,  15, 16, 1, 0);
    add("up_full",    1, 1, 0, 0,  0, 0,  0, 16, 1, 0);
    add("mod2",       1, 1, 0, 0,  1, 2,  0, 2,  0, 0);
    add("m2_up",      1, 1, 0, 0,  0, 0,  1, 2,  0, 0);
    add("m2_wrap_a",  1, 1, 0, 0,  0, 0,  0, 2,  1, 0);
    add("m2_wrap_b",  1, 0, 0, 0,  0, 0,  1, 2,  1, 0);
    add("m2_wrap_c",  1, 1, 0, 0,  0, 0,  0, 2,  1, 0);
    add("hold",       0, 0, 0, 0,  0, 0,  0, 2,  0, 0);
    add("ld15_clamp", 1, 1, 1, 15, 0, 0,  1, 2,  0, 1);
    add("mod0_bad",   1, 1, 0, 0,  1, 0,  1, 2,  0, 1);
    add("mod12",      0, 1, 0, 0,  1, 12, 0, 12, 0, 0);
    for (int k = 1; k <= 6; k++) add($sformatf("m12_up%0d", k), 1, 1, 0, 0, 0, 0, k, 12, 0, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_q", int'(bw.o_Q), 0);
    chk("rst_mod", int'(bw.o_mod), 10);
    chk("rst_tc", int'(bw.o_tc), 0);
    chk("rst_err", int'(bw.o_err), 0);

    // free-running up count with modulus 10
    bw.i_en = 1; bw.i_up_down = 1;
    for (int k = 1; k <= 27; k++) begin
      tick();
      $display("count step %0d: q=%0d tc=%0d", k, bw.o_Q, bw.o_tc);
      chk($sformatf("cnt_q%0d", k), int'(bw.o_Q), k % 10);
      chk($sformatf("cnt_tc%0d", k), int'(bw.o_tc), (k % 10 == 0) ? 1 : 0);
    end

    foreach (vecs[i]) begin
      bw.i_en = vecs[i].en; bw.i_up_down = vecs[i].ud; bw.i_load = vecs[i].ld;
      bw.i_load_val = vecs[i].lv; bw.i_mod_wr = vecs[i].mw; bw.i_mod_val = vecs[i].mv;
      tick();
      $display("vec %s: q=%0d mod=%0d tc=%0d err=%0d", vecs[i].name, bw.o_Q, bw.o_mod, bw.o_tc, bw.o_err);
      chk({vecs[i].name, "_q"},   int'(bw.o_Q),   int'(vecs[i].q));
      chk({vecs[i].name, "_mod"}, int'(bw.o_mod), int'(vecs[i].m));
      chk({vecs[i].name, "_tc"},  int'(bw.o_tc),  int'(vecs[i].tc));
      chk({vecs[i].name, "_err"}, int'(bw.o_err), int'(vecs[i].err));
    end

    // asynchronous reset between edges with q=6, mod=12, still counting up
    bw.i_load = 0; bw.i_mod_wr = 0; bw.i_en = 1; bw.i_up_down = 1;
    #3 rst = 1'b1;
    #1;
    $display("async reset: q=%0d mod=%0d tc=%0d", bw.o_Q, bw.o_mod, bw.o_tc);
    chk("arst_q", int'(bw.o_Q), 0);
    chk("arst_mod", int'(bw.o_mod), 10);
    chk("arst_tc", int'(bw.o_tc), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    $display("after reset release: q=%0d", bw.o_Q);
    chk("arst_resume_q", int'(bw.o_Q), 1);
    bw.i_en = 0;

    // saturate mode, modulus 6
    bs.i_mod_wr = 1; bs.i_mod_val = 5'd6;
    tick();
    bs.i_mod_wr = 0;
    chk("sat_mod", int'(bs.o_mod), 6);
    chk("sat_q0", int'(bs.o_Q), 0);
    bs.i_en = 1; bs.i_up_down = 1; tcs = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      tcs += int'(bs.o_tc);
      $display("sat up %0d: q=%0d tc=%0d", k, bs.o_Q, bs.o_tc);
      chk($sformatf("sat_up_q%0d", k), int'(bs.o_Q), (k < 5) ? k : 5);
    end
    chk("sat_up_tc_count", tcs, 1);
    bs.i_up_down = 0; tcs = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      tcs += int'(bs.o_tc);
      $display("sat down %0d: q=%0d tc=%0d", k, bs.o_Q, bs.o_tc);
      chk($sformatf("sat_dn_q%0d", k), int'(bs.o_Q), (k < 5) ? 5 - k : 0);
    end
    chk("sat_dn_tc_count", tcs, 1);
    bs.i_en = 0;

    // prescaled instance (PRE_DIV=4)
    bp.i_en = 1; bp.i_up_down = 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
      exp_q = k / 4;
`else
      exp_q = k % 10;
`endif
      $display("psc step %0d: q=%0d", k, bp.o_Q);
      chk($sformatf("psc_q%0d", k), int'(bp.o_Q), exp_q);
    end
    repeat (2) tick();
    bp.i_en = 0;
    repeat (2) tick();
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
    exp_q = 3;
`else
    exp_q = 4;
`endif
    chk("psc_hold_q", int'(bp.o_Q), exp_q);
    bp.i_en = 1;
    tick();
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
    exp_q = 3;
`else
    exp_q = 5;
`endif
    chk("psc_phase_a", int'(bp.o_Q), exp_q);
    tick();
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
    exp_q = 4;
`else
    exp_q = 6;
`endif
    chk("psc_phase_b", int'(bp.o_Q), exp_q);
    repeat (2) tick();
    bp.i_load = 1; bp.i_load_val = 4'd1;
    tick();
    bp.i_load = 0;
    chk("psc_load_q", int'(bp.o_Q), 1);
    repeat (3) tick();
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
    exp_q = 1;
`else
    exp_q = 4;
`endif
    chk("psc_restart_a", int'(bp.o_Q), exp_q);
    tick();
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
    exp_q = 2;
`else
    exp_q = 5;
`endif
    chk("psc_restart_b", int'(bp.o_Q), exp_q);
    $display("psc final: q=%0d", bp.o_Q);
    bp.i_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
